sound_arbiter: RTL and testbench

Parametrised N-channel sound arbiter that replaces the fixed two-input hit/music mux in the audio path. It selects one of `NUM_CH` note sources by fixed priority and drives the tone generator's note/enable inputs. It also stretches short request pulses to a minimum audible duration, optionally preempts lower-priority sounds, and inserts a programmable silence gap on channel switches so note changes are audible.

---
 rtl/sound_pkg.sv | 18 +
 rtl/sound_prio_enc.sv | 23 ++
 rtl/sound_arbiter.sv | 148 ++++++++++++++
 tb/tb_sound_arbiter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// Shared definitions for the audio path: arbiter state encoding and the
// default note width used by both the arbiter and the tone generator.
package sound_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

  localparam int DEFAULT_NOTE_W = 4;

  // Index width for n channels, kept at least 1 so a single-channel build still has a port.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sound_prio_enc.sv
// Lowest-index-wins priority encoder: channel 0 beats every other channel.
module sound_prio_enc #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = 2
) (
  input  logic [NUM_CH-1:0] req,
  output logic              winValid,
  output logic [IDX_W-1:0]  winIdx
);

  // Scanning from the top down lets the lowest requesting index overwrite the rest.
  always_comb begin
    winValid = 1'b0;
    winIdx   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) begin
        winValid = 1'b1;
        winIdx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/sound_arbiter.sv
// Fixed-priority sound arbiter: grants one note source to the tone generator,
// stretches short requests to a minimum hold and inserts a silence gap on switches.
module sound_arbiter
  import sound_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int NOTE_W     = DEFAULT_NOTE_W,
  parameter int MIN_HOLD   = 5_000_000,
  parameter int GAP_CYCLES = 1000,
  parameter int PREEMPT    = 1
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic [NUM_CH*NOTE_W-1:0]    noteIn,
  input  logic [NUM_CH-1:0]           playRequest,
  output logic [NOTE_W-1:0]           noteOut,
  output logic                        soundEnable,
  output logic [idxWidth(NUM_CH)-1:0] activeCh
);

  localparam int CH_W   = idxWidth(NUM_CH);
  localparam int HOLD_W = $clog2(MIN_HOLD + 1);
  localparam int GAP_W  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(MIN_HOLD - 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  arb_state_t        state, stateNext;
  logic [HOLD_W-1:0] holdCnt, holdNext;
  logic [GAP_W-1:0]  gapCnt, gapNext;
  logic [NOTE_W-1:0] noteNext;
  logic              enNext;
  logic [CH_W-1:0]   chNext;

  logic              winValid;
  logic [CH_W-1:0]   winIdx;
  logic [NOTE_W-1:0] noteArr [NUM_CH];
  logic              activeReq;
  logic              switchNow;

  sound_prio_enc #(
    .NUM_CH (NUM_CH),
    .IDX_W  (CH_W)
  ) prioEnc (
    .req      (playRequest),
    .winValid (winValid),
    .winIdx   (winIdx)
  );

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      noteArr[i] = noteIn[i*NOTE_W +: NOTE_W];
    end
  end

  assign activeReq = playRequest[activeCh];
  assign switchNow = (winValid && (winIdx < activeCh) && ((PREEMPT != 0) || (holdCnt == '0))) ||
                     (!activeReq && (holdCnt == '0));

  // Next-state logic also computes the next output values so every output is a flop.
  always_comb begin
    stateNext = state;
    holdNext  = holdCnt;
    gapNext   = gapCnt;
    noteNext  = noteOut;
    enNext    = soundEnable;
    chNext    = activeCh;

    unique case (state)
      IDLE: begin
        noteNext = '0;
        enNext   = 1'b0;
        chNext   = '0;
        if (winValid) begin
          stateNext = PLAY;
          chNext    = winIdx;
          holdNext  = HOLD_LOAD;
          noteNext  = noteArr[winIdx];
          enNext    = 1'b1;
        end
      end

      PLAY: begin
        if (switchNow) begin
          if (GAP_CYCLES > 0) begin
            stateNext = GAP;
            gapNext   = GAP_LOAD;
            noteNext  = '0;
            enNext    = 1'b0;
          end else if (winValid) begin
            chNext   = winIdx;
            holdNext = HOLD_LOAD;
            noteNext = noteArr[winIdx];
          end else begin
            stateNext = IDLE;
            noteNext  = '0;
            enNext    = 1'b0;
            chNext    = '0;
          end
        end else begin
          if (holdCnt != '0) holdNext = holdCnt - 1'b1;
          if (activeReq) noteNext = noteArr[activeCh];
        end
      end

      GAP: begin
        // Only requests still present when the gap ends are considered.
        if (gapCnt != '0) begin
          gapNext = gapCnt - 1'b1;
        end else if (winValid) begin
          stateNext = PLAY;
          chNext    = winIdx;
          holdNext  = HOLD_LOAD;
          noteNext  = noteArr[winIdx];
          enNext    = 1'b1;
        end else begin
          stateNext = IDLE;
          chNext    = '0;
        end
      end

      default: begin
        stateNext = IDLE;
        noteNext  = '0;
        enNext    = 1'b0;
        chNext    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= IDLE;
      holdCnt     <= '0;
      gapCnt      <= '0;
      noteOut     <= '0;
      soundEnable <= 1'b0;
      activeCh    <= '0;
    end else begin
      state       <= stateNext;
      holdCnt     <= holdNext;
      gapCnt      <= gapNext;
      noteOut     <= noteNext;
      soundEnable <= enNext;
      activeCh    <= chNext;
    end
  end

endmodule

// File: tb/tb_sound_arbiter.sv
// Directed self-checking bench for sound_arbiter with MIN_HOLD=4, GAP_CYCLES=2;
// a second instance with PREEMPT=0 shares the stimulus.
module tb_sound_arbiter;

  logic        clk = 1'b0;
  logic        resetN;
  logic [15:0] noteIn;
  logic [3:0]  playRequest;
  logic [3:0]  noteOut, noteOutNp;
  logic        soundEnable, soundEnableNp;
  logic [1:0]  activeCh, activeChNp;

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  sound_arbiter #(
    .NUM_CH(4), .NOTE_W(4), .MIN_HOLD(4), .GAP_CYCLES(2), .PREEMPT(1)
  ) dut (
    .clk(clk), .resetN(resetN), .noteIn(noteIn), .playRequest(playRequest),
    .noteOut(noteOut), .soundEnable(soundEnable), .activeCh(activeCh)
  );

  sound_arbiter #(
    .NUM_CH(4), .NOTE_W(4), .MIN_HOLD(4), .GAP_CYCLES(2), .PREEMPT(0)
  ) dutNp (
    .clk(clk), .resetN(resetN), .noteIn(noteIn), .playRequest(playRequest),
    .noteOut(noteOutNp), .soundEnable(soundEnableNp), .activeCh(activeChNp)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] req, input logic [15:0] notes);
    playRequest = req;
    noteIn      = notes;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks the preempting instance; cycle numbers refer to the scenario's own count.
  task automatic checkDut(input string tag, input int cyc, input int note, input int en, input int ch);
    checkOutput($sformatf("%s c%0d note", tag, cyc), 32'(noteOut), 32'(note));
    checkOutput($sformatf("%s c%0d en", tag, cyc), 32'(soundEnable), 32'(en));
    checkOutput($sformatf("%s c%0d ch", tag, cyc), 32'(activeCh), 32'(ch));
  endtask

  task automatic doReset();
    resetN = 1'b0;
    applyStimulus(4'b0000, 16'h0000);
    step();
    resetN = 1'b1;
    step();
  endtask

  initial begin
    resetN = 1'b0;
    applyStimulus(4'b0000, 16'h0000);
    #2;
    checkDut("reset", 0, 0, 0, 0);
    step();
    resetN = 1'b1;
    step();
    checkDut("idle", 0, 0, 0, 0);

    // Held request on ch3 for cycles 0..9.
    doReset();
    for (int c = 0; c < 10; c++) begin
      applyStimulus(4'b1000, 16'h5000);
      step();
      checkDut("held", c + 1, 5, 1, 3);
    end
    for (int c = 10; c < 13; c++) begin
      applyStimulus(4'b0000, 16'h5000);
      step();
      checkOutput($sformatf("held c%0d note", c + 1), 32'(noteOut), 32'd0);
      checkOutput($sformatf("held c%0d en", c + 1), 32'(soundEnable), 32'd0);
    end
    checkOutput("held c13 ch", 32'(activeCh), 32'd0);

    // One-cycle pulse on ch0 is stretched to four enabled cycles.
    doReset();
    applyStimulus(4'b0001, 16'h0009);
    step();
    checkDut("pulse", 1, 9, 1, 0);
    for (int c = 1; c < 4; c++) begin
      applyStimulus(4'b0000, 16'h0009);
      step();
      checkDut("pulse", c + 1, 9, 1, 0);
    end
    applyStimulus(4'b0000, 16'h0009);
    step();
    checkOutput("pulse c5 en", 32'(soundEnable), 32'd0);
    checkOutput("pulse c5 note", 32'(noteOut), 32'd0);

    // ch2 plays note 3, ch0 preempts with note 7 at cycle 6.
    doReset();
    for (int c = 0; c < 6; c++) begin
      applyStimulus(4'b0100, 16'h0300);
      step();
    end
    checkDut("preempt", 6, 3, 1, 2);
    for (int c = 6; c < 8; c++) begin
      applyStimulus(4'b0101, 16'h0307);
      step();
      checkDut("preempt", c + 1, 0, 0, 2);
    end
    applyStimulus(4'b0101, 16'h0307);
    step();
    checkDut("preempt", 9, 7, 1, 0);

    // PREEMPT=0 instance: ch0 waits for ch2's hold to expire.
    doReset();
    applyStimulus(4'b0100, 16'h0307);
    step();
    for (int c = 1; c < 8; c++) begin
      int expNote, expEn, expCh;
      if (c <= 4) begin
        expNote = 3; expEn = 1; expCh = 2;
      end else if (c <= 6) begin
        expNote = 0; expEn = 0; expCh = 2;
      end else begin
        expNote = 7; expEn = 1; expCh = 0;
      end
      checkOutput($sformatf("nopre c%0d note", c), 32'(noteOutNp), 32'(expNote));
      checkOutput($sformatf("nopre c%0d en", c), 32'(soundEnableNp), 32'(expEn));
      checkOutput($sformatf("nopre c%0d ch", c), 32'(activeChNp), 32'(expCh));
      applyStimulus(4'b0101, 16'h0307);
      step();
    end

    // ch1 changes note 3 -> 4 mid-play; hold is not reloaded.
    doReset();
    for (int c = 0; c < 3; c++) begin
      applyStimulus(4'b0010, 16'h0030);
      step();
      checkDut("notechg", c + 1, 3, 1, 1);
    end
    applyStimulus(4'b0010, 16'h0040);
    step();
    checkDut("notechg", 4, 4, 1, 1);
    applyStimulus(4'b0000, 16'h0040);
    step();
    checkOutput("notechg c5 en", 32'(soundEnable), 32'd0);

    // Asynchronous reset while playing clears outputs without a clock edge.
    doReset();
    applyStimulus(4'b0010, 16'h00A0);
    step();
    checkDut("prereset", 1, 10, 1, 1);
    #2;
    resetN = 1'b0;
    #1;
    checkDut("asyncreset", 1, 0, 0, 0);
    applyStimulus(4'b0000, 16'h0000);
    step();
    resetN = 1'b1;
    step();
    step();
    checkDut("postreset", 2, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
